uart_rx_maj_sampler: RTL
========================

// Module: uart_rx_maj_sampler
// PURPOSE
//  Parametrised UART RX bit sampler: next generation of the fixed 3-sample majority sampler.
//  Synchronises RX_IN, takes NUM_SAMPLES samples centred on the bit midpoint and outputs a majority-voted bit.
//  Adds three outputs: a valid strobe, a noise flag (samples disagree) and a configuration-error flag.
//  Sits between the RX edge/bit counter (provides edge_cnt) and the RX FSM / deserializer.
// PARAMETERS
//  PRESCALE_W   6  width of Prescale and edge_cnt
//  NUM_SAMPLES  3  samples per bit; odd, 1..7; H = (NUM_SAMPLES-1)/2
//  SYNC_STAGES  2  RX_IN synchroniser depth; >=1
// PORTS
//  CLK          in   1           oversampling clock; edge_cnt advances once per CLK
//  RST          in   1           asynchronous, active-low reset
//  RX_IN        in   1           raw serial line, idle high
//  dat_samp_en  in   1           sampling enable from RX FSM
//  edge_cnt     in   PRESCALE_W  edge index within the current bit, 0..Prescale-1
//  Prescale     in   PRESCALE_W  oversampling ratio, even
//  sampled_bit  out  1           majority-voted bit; holds its value until the next decision
//  sample_valid out  1           1-cycle strobe: sampled_bit updated
//  noise_err    out  1           set with sample_valid if the samples were not unanimous; holds until next decision
//  cfg_err      out  1           registered: Prescale illegal for NUM_SAMPLES
// BEHAVIOUR
//  Reset values:
//   - sync chain = all 1s; sampled_bit=1; sample_valid=0; noise_err=0; cfg_err=0
//   - FSM returns to IDLE; sample count and sample register cleared
//  rx_s = last synchroniser stage. All samples use rx_s, so the sample point lags RX_IN by SYNC_STAGES CLKs.
//  Window arithmetic (PRESCALE_W+1 bits, no overflow):
//   - C = Prescale>>1
//   - first edge S = C-H, last edge E = C+H, decision edge D = E+1
//  cfg_err=1 when C<H or D>Prescale-1 (registered every cycle).
//  While cfg_err=1: no samples taken, sample_valid never asserts.
//  FSM states IDLE, COLLECT, HOLD:
//   - IDLE: when dat_samp_en=1 and edge_cnt==S -> store rx_s as sample 0, cnt=1, go to COLLECT
//   - COLLECT: for each edge_cnt in S+1..E, store rx_s at index cnt, cnt++
//   - COLLECT, at edge_cnt==D with cnt==NUM_SAMPLES:
//       - sampled_bit <= ones > H
//       - noise_err <= samples not all equal
//       - sample_valid <= 1 for one cycle (visible the cycle after edge D)
//       - go to HOLD
//   - COLLECT, edge_cnt outside S..D or a missed/repeated edge (cnt mismatch): discard, no strobe, go to IDLE
//   - HOLD: wait for edge_cnt==0 (bit wrap), then go to IDLE
//  dat_samp_en=0 in any state: go to IDLE next cycle, discard partial samples, hold sampled_bit and noise_err.
//  NUM_SAMPLES=1: S=E=C; the bit is the centre sample; noise_err is always 0.
//  Asynchronous reset mid-window: immediate reset values; no strobe after release until a full new window completes.
//  Prescale changes mid-bit: undefined result for that bit only; the next bit after wrap is correct.
// TESTING
//  T1 N=3, Prescale=8 (S=3,E=5,D=6), rx_s=1 on edges 3..5 -> sampled_bit=1, valid 1 cycle after edge 6, noise_err=0
//  T2 N=3, Prescale=8, rx_s=1,0,1 on edges 3,4,5 -> sampled_bit=1, noise_err=1; next bit rx_s all 0 -> sampled_bit=0, noise_err=0
//  T3 N=5, Prescale=16 (S=6,E=10), rx_s=0 on edges 6,9 -> sampled_bit=1, noise_err=1; rx_s=0 on edges 6,8,9 -> sampled_bit=0
//  T4 N=3, Prescale=8, dat_samp_en dropped at edge 4 -> no sample_valid; sampled_bit keeps its previous value
//  T5 N=5, Prescale=2 -> cfg_err=1, no sample_valid for 3 full bit periods; Prescale=16 -> cfg_err=0 after 1 cycle
//  T6 RST low at edge 4 of a window, released at edge 7 -> reset values; no strobe until the following bit's edge D

Source files
------------

// File: rtl/uart_rx_maj_sampler_if.sv
// Sampler-facing bundle: line/timing inputs from the RX counter and FSM, voted-bit results back.
interface uart_rx_maj_sampler_if #(
  parameter int unsigned PRESCALE_W = 6
);
  logic                  RX_IN;
  logic                  dat_samp_en;
  logic [PRESCALE_W-1:0] edge_cnt;
  logic [PRESCALE_W-1:0] Prescale;
  logic                  sampled_bit;
  logic                  sample_valid;
  logic                  noise_err;
  logic                  cfg_err;

  modport master (
    output RX_IN, dat_samp_en, edge_cnt, Prescale,
    input  sampled_bit, sample_valid, noise_err, cfg_err
  );

  modport slave (
    input  RX_IN, dat_samp_en, edge_cnt, Prescale,
    output sampled_bit, sample_valid, noise_err, cfg_err
  );
endinterface

// File: rtl/uart_rx_maj_sampler.sv
// UART RX bit sampler: synchronises RX_IN, collects NUM_SAMPLES samples centred on the bit
// midpoint and emits a majority-voted bit with valid strobe, noise flag and config-error flag.
module uart_rx_maj_sampler #(
  parameter int unsigned PRESCALE_W  = 6,
  parameter int unsigned NUM_SAMPLES = 3,
  parameter int unsigned SYNC_STAGES = 2
) (
  input logic                 CLK,
  input logic                 RST,
  uart_rx_maj_sampler_if.slave bus
);

  localparam int unsigned WW = PRESCALE_W + 1;
  localparam int unsigned H  = (NUM_SAMPLES - 1) / 2;
  localparam int unsigned CW = $clog2(NUM_SAMPLES + 1);

  typedef enum logic [1:0] {IDLE, COLLECT, HOLD} state_e;

  state_e                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [NUM_SAMPLES-1:0] samp_q, samp_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   sampled_bit_q, sampled_bit_d;
  logic                   noise_err_q, noise_err_d;
  logic                   sample_valid_q, sample_valid_d;
  logic                   cfg_err_q, cfg_err_d;

  logic                   rx_s;
  logic [WW-1:0]          p_w, c_w, s_w, e_w, d_w, edge_w, off_w;
  logic                   in_win;
  logic [CW-1:0]          ones;
  logic                   all_same;

  // Window edges, one bit wider than Prescale so C+H+1 cannot wrap
  assign p_w    = WW'(bus.Prescale);
  assign c_w    = p_w >> 1;
  assign s_w    = c_w - WW'(H);
  assign e_w    = c_w + WW'(H);
  assign d_w    = e_w + WW'(1);
  assign edge_w = WW'(bus.edge_cnt);
  assign off_w  = edge_w - s_w;
  assign in_win = (edge_w > s_w) && (edge_w <= e_w) && (off_w == WW'(cnt_q));

  assign cfg_err_d = (c_w < WW'(H)) || (d_w >= p_w);

  always_comb begin
    sync_d    = sync_q;
    sync_d[0] = bus.RX_IN;
    for (int i = 1; i < SYNC_STAGES; i++) sync_d[i] = sync_q[i-1];
  end

  assign rx_s = sync_q[SYNC_STAGES-1];

  always_comb begin
    ones = '0;
    for (int i = 0; i < NUM_SAMPLES; i++) ones = ones + CW'(samp_q[i]);
  end

  assign all_same = (&samp_q) || (~|samp_q);

  // Next-state and registered-output logic
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    samp_d         = samp_q;
    sampled_bit_d  = sampled_bit_q;
    noise_err_d    = noise_err_q;
    sample_valid_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.dat_samp_en && !cfg_err_q && (edge_w == s_w)) begin
          samp_d    = '0;
          samp_d[0] = rx_s;
          cnt_d     = CW'(1);
          state_d   = COLLECT;
        end
      end
      COLLECT: begin
        state_d = IDLE;
        cnt_d   = '0;
        if (bus.dat_samp_en && !cfg_err_q) begin
          if (in_win) begin
            for (int i = 0; i < NUM_SAMPLES; i++) begin
              if (CW'(i) == cnt_q) samp_d[i] = rx_s;
            end
            cnt_d   = cnt_q + CW'(1);
            state_d = COLLECT;
          end else if ((edge_w == d_w) && (cnt_q == CW'(NUM_SAMPLES))) begin
            sampled_bit_d  = ones > CW'(H);
            noise_err_d    = !all_same;
            sample_valid_d = 1'b1;
            state_d        = HOLD;
          end
        end
      end
      HOLD: begin
        // Stay parked until the bit counter wraps so one bit yields one decision
        if (!bus.dat_samp_en || (edge_w == '0)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q        <= IDLE;
      sync_q         <= '1;
      samp_q         <= '0;
      cnt_q          <= '0;
      sampled_bit_q  <= 1'b1;
      noise_err_q    <= 1'b0;
      sample_valid_q <= 1'b0;
      cfg_err_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      sync_q         <= sync_d;
      samp_q         <= samp_d;
      cnt_q          <= cnt_d;
      sampled_bit_q  <= sampled_bit_d;
      noise_err_q    <= noise_err_d;
      sample_valid_q <= sample_valid_d;
      cfg_err_q      <= cfg_err_d;
    end
  end

  assign bus.sampled_bit  = sampled_bit_q;
  assign bus.noise_err    = noise_err_q;
  assign bus.sample_valid = sample_valid_q;
  assign bus.cfg_err      = cfg_err_q;

endmodule
